// File: rtl/rom_seq_player.sv
// rom_seq_player
//   Plays back the contents of a sequential ROM. On start it rewinds the ROM,
//   fetches words until the ROM reports end, repeats for the latched pass count
//   and streams the words to a valid/ready sink through a 2-entry FIFO.
// Ports
//   clock, reset        : system clock; asynchronous active-high reset
//   start, abort, loops : control; loops latched on start (0 means 1 pass)
//   busy, done, words   : status; done is a one-cycle pulse, words counts pops
//   rom_rewind, rom_req : ROM sync reset and advance strobe
//   rom_valid, rom_data : ROM word at the current index
//   out_valid, out_ready, out_data : sink handshake from the FIFO head
module rom_seq_player #(
   parameter int W  = 8,
   parameter int LW = 8,
   parameter int CW = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [LW-1:0] loops,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] words,
   output logic          rom_rewind,
   output logic          rom_req,
   input  logic          rom_valid,
   input  logic [W-1:0]  rom_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data
);

   typedef enum logic [1:0] {IDLE, REWIND, RUN, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  mem [2];
   logic          rd_ptr, wr_ptr;
   logic [1:0]    fill;
   logic [LW-1:0] passes_left;
   logic          launch, finish, next_pass;
   logic          push, pop;

   assign busy      = (state != IDLE);
   assign out_valid = (fill != 2'd0);
   assign out_data  = mem[rd_ptr];
   assign pop       = out_valid && out_ready;
   // rom_req is only raised while rom_valid is high, so a request is a push
   assign push      = rom_req;

   // Next state and ROM strobes; deliberately independent of out_ready so
   // there is no combinational path from the sink back to the ROM.
   always_comb begin
      state_nxt  = state;
      rom_rewind = 1'b0;
      rom_req    = 1'b0;
      launch     = 1'b0;
      finish     = 1'b0;
      next_pass  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               launch    = 1'b1;
               state_nxt = REWIND;
            end
         end
         REWIND: begin
            rom_rewind = 1'b1;
            state_nxt  = RUN;
         end
         RUN: begin
            rom_req = rom_valid && (fill != 2'd2);
            if (!rom_valid) begin
               if (passes_left > LW'(1)) begin
                  next_pass = 1'b1;
                  state_nxt = REWIND;
               end else begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (fill == 2'd0) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (abort) begin
         state_nxt = IDLE;
         finish    = 1'b0;
         next_pass = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         done        <= 1'b0;
         passes_left <= '0;
         words       <= '0;
      end else begin
         state <= state_nxt;
         done  <= finish;
         if (launch)
            passes_left <= (loops == '0) ? LW'(1) : loops;
         else if (next_pass)
            passes_left <= passes_left - LW'(1);
         if (launch)
            words <= '0;
         else if (pop)
            words <= words + CW'(1);
      end
   end

   // FIFO; abort flushes it, but a handshake in the abort cycle still counts
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 2; i++)
            mem[i] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         fill   <= 2'd0;
      end else if (abort) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         fill   <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= rom_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         fill <= fill + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_rom_seq_player.sv
// tb_rom_seq_player
//   Directed bench for rom_seq_player with a 4-word ROM model (10..13).
//   Expected words are queued when a playback is started and popped on every
//   sink handshake.
module tb_rom_seq_player;

   logic        clock = 1'b0;
   logic        reset;
   logic        start, abort;
   logic [7:0]  loops;
   logic        busy, done;
   logic [15:0] words;
   logic        rom_rewind, rom_req, rom_valid;
   logic [7:0]  rom_data;
   logic        out_valid, out_ready;
   logic [7:0]  out_data;

   int total = 0;
   int bad   = 0;

   logic [7:0] sb[$];
   int  cyc = 0;
   int  rewinds = 0, dones = 0;
   int  hs_cnt = 0, first_hs = 0, last_hs = 0, resumes = 0;
   bit  prev_hs = 0;
   bit  toggle = 0;
   bit  chk_fill = 0;
   int  fill_m = 0;

   always #5 clock = ~clock;

   rom_seq_player #(.W(8), .LW(8), .CW(16)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort), .loops(loops),
      .busy(busy), .done(done), .words(words),
      .rom_rewind(rom_rewind), .rom_req(rom_req), .rom_valid(rom_valid),
      .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data)
   );

   // ROM model: 4 words, sync reset from rom_rewind | reset
   logic [2:0] idx;
   assign rom_valid = (idx < 3'd4);
   assign rom_data  = 8'd10 + {5'd0, idx};
   always @(posedge clock) begin
      if (rom_rewind || reset)
         idx <= 3'd0;
      else if (rom_req && rom_valid)
         idx <= idx + 3'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      if (toggle) out_ready = ~out_ready;
   endtask

   task automatic push_pass();
      for (int i = 0; i < 4; i++) sb.push_back(8'(10 + i));
   endtask

   task automatic clear_stats();
      hs_cnt = 0; first_hs = 0; last_hs = 0; resumes = 0; prev_hs = 0;
   endtask

   task automatic wait_done(input int budget);
      bit got;
      got = 0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done === 1'b1) begin
            got = 1;
            break;
         end
      end
      chk("done_seen", 32'(got), 32'd1);
   endtask

   task automatic pulse_start(input logic [7:0] n);
      loops = n;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Monitor on the falling edge: scoreboard, pulse counters, fill model
   always @(negedge clock) begin
      bit hs;
      cyc++;
      if (!reset) begin
         if (rom_rewind) rewinds++;
         if (done) dones++;
         hs = out_valid && out_ready;
         if (hs) begin
            total++;
            assert (sb.size() != 0) else begin
               bad++;
               $error("FAIL unexpected_word: observed=%0d expected=none", out_data);
            end
            if (sb.size() != 0) chk("out_data", 32'(out_data), 32'(sb.pop_front()));
            if (hs_cnt > 0 && !prev_hs) resumes++;
            if (hs_cnt == 0) first_hs = cyc;
            last_hs = cyc;
            hs_cnt++;
         end
         prev_hs = hs;
         if (chk_fill) begin
            if (fill_m == 2) chk("req_when_full", 32'(rom_req), 32'd0);
            fill_m = fill_m + int'(rom_req && rom_valid) - int'(hs);
            if (abort) fill_m = 0;
         end else begin
            fill_m = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r0, d0;
      reset = 1'b1; start = 1'b0; abort = 1'b0; loops = 8'd0; out_ready = 1'b1;
      step(); step();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_words", 32'(words), 0);
      chk("rst_rewind", 32'(rom_rewind), 0);
      chk("rst_req", 32'(rom_req), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      reset = 1'b0;
      step();

      // 1: single pass, latency and back-to-back output
      clear_stats(); r0 = rewinds; d0 = dones;
      push_pass();
      pulse_start(8'd1);
      chk("t1_rewind_after_start", 32'(rom_rewind), 1);
      step();
      chk("t1_valid_after_2_edges", 32'(out_valid), 0);
      step();
      chk("t1_valid_after_3_edges", 32'(out_valid), 1);
      wait_done(50);
      chk("t1_words", 32'(words), 4);
      chk("t1_busy_with_done", 32'(busy), 0);
      step();
      chk("t1_done_one_cycle", 32'(done), 0);
      chk("t1_hs_count", 32'(hs_cnt), 4);
      chk("t1_consecutive", 32'(last_hs - first_hs), 3);
      chk("t1_sb_empty", 32'(sb.size()), 0);
      chk("t1_rewinds", 32'(rewinds - r0), 1);
      chk("t1_dones", 32'(dones - d0), 1);

      // 2: three passes; each pass boundary costs the end-detect cycle plus
      // the rewind cycle, forming a single gap in the stream
      clear_stats(); r0 = rewinds;
      push_pass(); push_pass(); push_pass();
      pulse_start(8'd3);
      wait_done(100);
      chk("t2_words", 32'(words), 12);
      chk("t2_rewinds", 32'(rewinds - r0), 3);
      chk("t2_gaps", 32'(resumes), 2);
      chk("t2_gap_cycles", 32'(last_hs - first_hs + 1 - 12), 4);
      chk("t2_sb_empty", 32'(sb.size()), 0);
      step();
      r0 = rewinds;
      push_pass();
      pulse_start(8'd0);
      wait_done(50);
      chk("t2_loops0_words", 32'(words), 4);
      chk("t2_loops0_rewinds", 32'(rewinds - r0), 1);
      chk("t2_loops0_sb_empty", 32'(sb.size()), 0);
      step();

      // 3: two passes with a sink that accepts every other cycle
      chk_fill = 1; toggle = 1;
      push_pass(); push_pass();
      pulse_start(8'd2);
      wait_done(200);
      chk("t3_words", 32'(words), 8);
      chk("t3_sb_empty", 32'(sb.size()), 0);
      toggle = 0; out_ready = 1'b1; chk_fill = 0;
      step();

      // 4: abort once the second word is accepted
      d0 = dones;
      push_pass();
      pulse_start(8'd1);
      step(); step(); step(); step();
      abort = 1'b1; out_ready = 1'b0;
      sb.delete();
      step();
      abort = 1'b0; out_ready = 1'b1;
      chk("t4_out_valid", 32'(out_valid), 0);
      chk("t4_busy", 32'(busy), 0);
      chk("t4_words", 32'(words), 2);
      step(); step(); step();
      chk("t4_no_done", 32'(dones - d0), 0);
      chk("t4_words_hold", 32'(words), 2);
      push_pass();
      pulse_start(8'd1);
      wait_done(50);
      chk("t4_restart_words", 32'(words), 4);
      chk("t4_restart_sb_empty", 32'(sb.size()), 0);
      step();

      // 5: asynchronous reset pulse between edges during RUN
      push_pass(); push_pass();
      pulse_start(8'd2);
      step(); step(); step(); step();
      #1 reset = 1'b1;
      #1;
      chk("t5_busy", 32'(busy), 0);
      chk("t5_out_valid", 32'(out_valid), 0);
      chk("t5_rom_req", 32'(rom_req), 0);
      chk("t5_words", 32'(words), 0);
      sb.delete();
      #1 reset = 1'b0;
      step();
      push_pass();
      pulse_start(8'd1);
      wait_done(50);
      chk("t5_after_words", 32'(words), 4);
      chk("t5_after_sb_empty", 32'(sb.size()), 0);
      step();

      // 6: start while busy is ignored; start with abort in IDLE does nothing
      r0 = rewinds;
      push_pass();
      pulse_start(8'd1);
      step(); step(); step();
      start = 1'b1; loops = 8'd3;
      step(); step();
      start = 1'b0;
      wait_done(50);
      chk("t6_busy_start_words", 32'(words), 4);
      chk("t6_busy_start_rewinds", 32'(rewinds - r0), 1);
      chk("t6_busy_start_sb_empty", 32'(sb.size()), 0);
      step();
      r0 = rewinds;
      start = 1'b1; abort = 1'b1;
      step(); step(); step();
      chk("t6_start_abort_busy", 32'(busy), 0);
      start = 1'b0; abort = 1'b0;
      step();
      chk("t6_start_abort_rewinds", 32'(rewinds - r0), 0);
      chk("t6_start_abort_words", 32'(words), 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
